// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous RAM port between the
// instruction-fetch requester (IF, read-only) and the data-memory requester
// (ME, read/write with byte enables).
//
// Each 32-bit access is split into four little-endian byte accesses on the
// RAM port. Read bytes return one cycle after their address and are
// reassembled into the granted requester's data register.
//
// Transaction timing, counted from the IDLE cycle T that accepts a request:
//   read : RD in T+1..T+5 (cnt 0..4), DONE in T+6
//   write: WR in T+1..T+4 (cnt 0..3), DONE in T+5
//
// Optional build macro: MEM_ARB_RR_EN
//   undefined : ME has fixed priority over IF on a tie
//   defined   : on a tie, grant the requester not served last (resets to IF,
//               so ME wins the first tie)
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch requester
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  output logic              if_stall_req_o,
  // data-memory requester
  input  logic              me_req_i,
  input  logic              me_we_i,
  input  logic [ADDR_W-1:0] me_addr_i,
  input  logic [3:0]        me_sel_i,
  input  logic [31:0]       me_w_data_i,
  output logic [31:0]       me_r_data_o,
  output logic              me_done_o,
  output logic              me_stall_req_o,
  // byte-wide RAM port
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_w_data_o,
  output logic              mem_we_o,
  input  logic [7:0]        mem_r_data_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  typedef enum logic {
    G_IF,
    G_ME
  } grant_t;

  // transaction state
  state_t            r_state;
  logic [2:0]        r_cnt;
  grant_t            r_grant;
  logic [ADDR_W-1:0] r_base;
  logic [3:0]        r_sel;
  logic [31:0]       r_w_data;

  // registered outputs
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_w_data;
  logic              r_mem_we;
  logic [31:0]       r_if_data;
  logic [31:0]       r_me_r_data;
  logic              r_if_done;
  logic              r_me_done;

`ifdef MEM_ARB_RR_EN
  // requester served by the most recently accepted transaction
  grant_t            r_last_grant;
`endif

  // arbitration and accept-time values
  logic              w_any_req;
  logic              w_grant_me;
  logic [ADDR_W-1:0] w_acc_addr;
  logic              w_acc_we;

  // byte-sequencing helpers
  logic [2:0]        w_cnt_inc;
  logic [ADDR_W-1:0] w_next_addr;
  logic [1:0]        w_rd_byte;
  logic [1:0]        w_wr_byte;
  logic [7:0]        w_next_w_byte;

  // Pick the requester to serve when IDLE and mux its request fields.
  always_comb begin
    w_any_req = if_req_i | me_req_i;
`ifdef MEM_ARB_RR_EN
    if (if_req_i && me_req_i) begin
      w_grant_me = (r_last_grant == G_IF);
    end else begin
      w_grant_me = me_req_i;
    end
`else
    w_grant_me = me_req_i;
`endif
    w_acc_addr = w_grant_me ? me_addr_i : if_addr_i;
    // IF is read-only, so only an ME grant can start a write
    w_acc_we   = w_grant_me & me_we_i;
  end

  // Derive next byte address and byte lanes from the byte counter.
  always_comb begin
    w_cnt_inc     = r_cnt + 3'd1;
    // wraps modulo 2^ADDR_W, so a word may straddle the top of memory
    w_next_addr   = r_base + ADDR_W'(w_cnt_inc);
    // read byte returned in cycle cnt belongs to lane cnt-1 (cnt 1..4 -> 0..3)
    w_rd_byte     = r_cnt[1:0] - 2'd1;
    // next write lane is the one after the current cnt
    w_wr_byte     = w_cnt_inc[1:0];
    w_next_w_byte = r_w_data[{w_wr_byte, 3'b000} +: 8];
  end

  // Arbitration FSM, byte sequencing, read reassembly and done pulses.
  // NOTE: sequential state is written only with <= so every register samples
  // the pre-edge values of its neighbours; mixing = here would create races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_grant      <= G_IF;
      r_base       <= '0;
      r_sel        <= 4'b0000;
      r_w_data     <= 32'd0;
      r_mem_addr   <= '0;
      r_mem_w_data <= 8'd0;
      r_mem_we     <= 1'b0;
      r_if_data    <= 32'd0;
      r_me_r_data  <= 32'd0;
      r_if_done    <= 1'b0;
      r_me_done    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last_grant <= G_IF;
`endif
    end else begin
      // done outputs are single-cycle pulses unless set below
      r_if_done <= 1'b0;
      r_me_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_mem_we <= 1'b0;
          if (w_any_req) begin
            r_grant    <= w_grant_me ? G_ME : G_IF;
            r_base     <= w_acc_addr;
            r_sel      <= me_sel_i;
            r_w_data   <= me_w_data_i;
            r_cnt      <= 3'd0;
            // byte 0 is presented in the first RD/WR cycle
            r_mem_addr <= w_acc_addr;
            if (w_acc_we) begin
              r_mem_w_data <= me_w_data_i[7:0];
              r_mem_we     <= me_sel_i[0];
              r_state      <= S_WR;
            end else begin
              r_state      <= S_RD;
            end
`ifdef MEM_ARB_RR_EN
            r_last_grant <= w_grant_me ? G_ME : G_IF;
`endif
          end
        end

        S_RD: begin
          r_mem_we <= 1'b0;
          if (r_cnt != 3'd0) begin
            if (r_grant == G_ME) begin
              r_me_r_data[{w_rd_byte, 3'b000} +: 8] <= mem_r_data_i;
            end else begin
              r_if_data[{w_rd_byte, 3'b000} +: 8]   <= mem_r_data_i;
            end
          end
          // addresses for bytes 1..3; the last address simply holds
          if (r_cnt < 3'd3) begin
            r_mem_addr <= w_next_addr;
          end
          if (r_cnt == 3'd4) begin
            r_state <= S_DONE;
            if (r_grant == G_ME) begin
              r_me_done <= 1'b1;
            end else begin
              r_if_done <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_WR: begin
          if (r_cnt == 3'd3) begin
            r_mem_we  <= 1'b0;
            r_state   <= S_DONE;
            r_me_done <= 1'b1;
          end else begin
            r_mem_addr   <= w_next_addr;
            r_mem_w_data <= w_next_w_byte;
            // disabled lanes still take a cycle, just without a strobe
            r_mem_we     <= r_sel[w_wr_byte];
            r_cnt        <= w_cnt_inc;
          end
        end

        S_DONE: begin
          r_mem_we <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_mem_we <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Stall requests drop in the cycle the done pulse is seen.
  assign if_stall_req_o = if_req_i & ~r_if_done;
  assign me_stall_req_o = me_req_i & ~r_me_done;

  assign if_data_o    = r_if_data;
  assign if_done_o    = r_if_done;
  assign me_r_data_o  = r_me_r_data;
  assign me_done_o    = r_me_done;
  assign mem_addr_o   = r_mem_addr;
  assign mem_w_data_o = r_mem_w_data;
  assign mem_we_o     = r_mem_we;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural byte RAM.
// Expected completions (requester + data word) are queued when a request is
// driven and compared when the matching done pulse appears.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic [31:0]       if_data_o;
  logic              if_done_o;
  logic              if_stall_req_o;
  logic              me_req_i = 1'b0;
  logic              me_we_i = 1'b0;
  logic [ADDR_W-1:0] me_addr_i = '0;
  logic [3:0]        me_sel_i = 4'b0000;
  logic [31:0]       me_w_data_i = 32'd0;
  logic [31:0]       me_r_data_o;
  logic              me_done_o;
  logic              me_stall_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_w_data_o;
  logic              mem_we_o;
  logic [7:0]        mem_r_data_i = 8'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_me;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] ram [logic [31:0]];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_i       (if_req_i),
    .if_addr_i      (if_addr_i),
    .if_data_o      (if_data_o),
    .if_done_o      (if_done_o),
    .if_stall_req_o (if_stall_req_o),
    .me_req_i       (me_req_i),
    .me_we_i        (me_we_i),
    .me_addr_i      (me_addr_i),
    .me_sel_i       (me_sel_i),
    .me_w_data_i    (me_w_data_i),
    .me_r_data_o    (me_r_data_o),
    .me_done_o      (me_done_o),
    .me_stall_req_o (me_stall_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_w_data_o   (mem_w_data_o),
    .mem_we_o       (mem_we_o),
    .mem_r_data_i   (mem_r_data_i)
  );

  // unwritten locations return an address-derived pattern
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ 8'hA5;
  endfunction

  // synchronous byte RAM: read data valid one cycle after the address
  always @(posedge clk) begin
    if (mem_we_o) ram[mem_addr_o] = mem_w_data_o;
    mem_r_data_i <= ram_rd(mem_addr_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // both done pulses must never coincide
  always @(negedge clk) begin
    if (!rst) check("done_exclusive", {31'd0, if_done_o & me_done_o}, 32'd0);
  end

  // wait for the next done pulse, check its latency, then score it
  task automatic wait_done(input string tag, input int exp_cyc);
    int   cyc;
    bit   seen;
    exp_t e;
    logic [31:0] obs;
    cyc  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (if_done_o || me_done_o) begin
        cyc  = i;
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_lat"}, cyc, exp_cyc);
      check({tag, "_sb"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        check({tag, "_who"}, {31'd0, me_done_o}, {31'd0, e.is_me});
        obs = e.is_me ? me_r_data_o : if_data_o;
        check({tag, "_data"}, obs, e.data);
      end
    end
  endtask

  // one cycle after a done: pulse gone, no write strobe
  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_if_done"}, {31'd0, if_done_o}, 32'd0);
    check({tag, "_me_done"}, {31'd0, me_done_o}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we_o}, 32'd0);
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] w);
    for (int b = 0; b < 4; b++) ram[a + 32'(b)] = w[8*b +: 8];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] last_me;
    logic [31:0] exp_a;
    logic [3:0]  sel_v;
    logic [31:0] wd_v;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_w_data_o}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_if_data", if_data_o, 32'd0);
    check("rst_me_data", me_r_data_o, 32'd0);
    check("rst_if_done", {31'd0, if_done_o}, 32'd0);
    check("rst_me_done", {31'd0, me_done_o}, 32'd0);
    rst = 1'b0;

    load_word(32'h0000_1000, 32'h4433_2211);
    load_word(32'h0000_2000, 32'h0403_0201);
    load_word(32'h0000_3000, 32'hA3A2_A1A0);
    load_word(32'h0000_7000, 32'h7473_7271);
    load_word(32'hFFFF_FFFE, 32'h0000_3412);
    load_word(32'h0000_0000, 32'h0000_7856);
    load_word(32'h0000_5000, 32'hC4C3_C2C1);
    load_word(32'h0000_6000, 32'hE4E3_E2E1);
    load_word(32'h0000_8000, 32'h8483_8281);
    load_word(32'h0000_4000, 32'h0000_0000);

    // ---------------- tie: ME first, then IF ----------------
    @(negedge clk);
    me_req_i  = 1'b1;
    me_we_i   = 1'b0;
    me_addr_i = 32'h0000_3000;
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_7000;
    sb_q.push_back('{1'b1, 32'hA3A2_A1A0});
    sb_q.push_back('{1'b0, 32'h7473_7271});
    #1;
    check("tie1_if_stall", {31'd0, if_stall_req_o}, 32'd1);
    check("tie1_me_stall", {31'd0, me_stall_req_o}, 32'd1);
    wait_done("tie1_me", 6);
    check("tie1_me_stall_done", {31'd0, me_stall_req_o}, 32'd0);
    check("tie1_if_wait_stall", {31'd0, if_stall_req_o}, 32'd1);
    me_req_i = 1'b0;
    wait_done("tie1_if", 7);
    if_req_i = 1'b0;
    idle_check("tie1_idle");
    last_me = 32'hA3A2_A1A0;

    // ---------------- IF read, cycle by cycle ----------------
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_1000;
    sb_q.push_back('{1'b0, 32'h4433_2211});
    #1;
    check("ifrd_stall_T", {31'd0, if_stall_req_o}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) check($sformatf("ifrd_addr%0d", k), mem_addr_o, 32'h0000_1000 + 32'(k - 1));
      check($sformatf("ifrd_we%0d", k), {31'd0, mem_we_o}, 32'd0);
      check($sformatf("ifrd_done%0d", k), {31'd0, if_done_o}, 32'd0);
      check($sformatf("ifrd_stall%0d", k), {31'd0, if_stall_req_o}, 32'd1);
    end
    wait_done("ifrd", 1);
    check("ifrd_stall_done", {31'd0, if_stall_req_o}, 32'd0);
    if_req_i = 1'b0;
    idle_check("ifrd_idle");

    // ---------------- ME write with sparse byte enables ----------------
    sel_v       = 4'b0101;
    wd_v        = 32'hAABB_CCDD;
    me_req_i    = 1'b1;
    me_we_i     = 1'b1;
    me_addr_i   = 32'h0000_2000;
    me_sel_i    = sel_v;
    me_w_data_i = wd_v;
    sb_q.push_back('{1'b1, last_me});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("mewr_addr%0d", k), mem_addr_o, 32'h0000_2000 + 32'(k - 1));
      check($sformatf("mewr_we%0d", k), {31'd0, mem_we_o}, {31'd0, sel_v[k-1]});
      if (sel_v[k-1]) check($sformatf("mewr_wdata%0d", k), {24'd0, mem_w_data_o}, {24'd0, wd_v[8*(k-1) +: 8]});
      check($sformatf("mewr_done%0d", k), {31'd0, me_done_o}, 32'd0);
    end
    wait_done("mewr", 1);
    check("mewr_we_in_done", {31'd0, mem_we_o}, 32'd0);
    me_req_i = 1'b0;
    me_we_i  = 1'b0;
    idle_check("mewr_idle");
    check("mewr_ram0", {24'd0, ram_rd(32'h0000_2000)}, 32'h0000_00DD);
    check("mewr_ram1", {24'd0, ram_rd(32'h0000_2001)}, 32'h0000_0002);
    check("mewr_ram2", {24'd0, ram_rd(32'h0000_2002)}, 32'h0000_00BB);
    check("mewr_ram3", {24'd0, ram_rd(32'h0000_2003)}, 32'h0000_0004);

    // ---------------- ME read wrapping the address space ----------------
    me_req_i  = 1'b1;
    me_addr_i = 32'hFFFF_FFFE;
    sb_q.push_back('{1'b1, 32'h7856_3412});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      exp_a = 32'hFFFF_FFFE + 32'(k - 1);
      check($sformatf("wrap_addr%0d", k), mem_addr_o, exp_a);
    end
    wait_done("wrap", 2);
    me_req_i = 1'b0;
    idle_check("wrap_idle");
    last_me = 32'h7856_3412;

    // ---------------- ME address changes mid-read ----------------
    me_req_i  = 1'b1;
    me_addr_i = 32'h0000_5000;
    sb_q.push_back('{1'b1, 32'hC4C3_C2C1});
    repeat (2) @(negedge clk);
    me_addr_i = 32'h0000_6000;
    @(negedge clk);
    check("chg_addr3", mem_addr_o, 32'h0000_5002);
    @(negedge clk);
    check("chg_addr4", mem_addr_o, 32'h0000_5003);
    wait_done("chg", 2);
    me_req_i = 1'b0;
    idle_check("chg_idle");
    last_me = 32'hC4C3_C2C1;

    // ---------------- second tie ----------------
    me_req_i  = 1'b1;
    me_addr_i = 32'h0000_7000;
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_8000;
`ifdef MEM_ARB_RR_EN
    sb_q.push_back('{1'b0, 32'h8483_8281});
    sb_q.push_back('{1'b1, 32'h7473_7271});
    wait_done("tie2_first", 6);
    if_req_i = 1'b0;
    wait_done("tie2_second", 7);
    me_req_i = 1'b0;
`else
    sb_q.push_back('{1'b1, 32'h7473_7271});
    sb_q.push_back('{1'b0, 32'h8483_8281});
    wait_done("tie2_first", 6);
    me_req_i = 1'b0;
    wait_done("tie2_second", 7);
    if_req_i = 1'b0;
`endif
    idle_check("tie2_idle");

    // ---------------- reset in the middle of a write ----------------
    me_req_i    = 1'b1;
    me_we_i     = 1'b1;
    me_addr_i   = 32'h0000_4000;
    me_sel_i    = 4'b1111;
    me_w_data_i = 32'h1122_3344;
    repeat (3) @(negedge clk);
    check("rstwr_we_cnt2", {31'd0, mem_we_o}, 32'd1);
    check("rstwr_addr_cnt2", mem_addr_o, 32'h0000_4002);
    check("rstwr_wdata_cnt2", {24'd0, mem_w_data_o}, 32'h0000_0022);
    rst      = 1'b1;
    me_req_i = 1'b0;
    me_we_i  = 1'b0;
    @(negedge clk);
    check("rstwr_we_after", {31'd0, mem_we_o}, 32'd0);
    check("rstwr_addr_after", mem_addr_o, 32'd0);
    check("rstwr_me_data", me_r_data_o, 32'd0);
    check("rstwr_if_data", if_data_o, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rstwr_no_done%0d", k), {30'd0, if_done_o, me_done_o}, 32'd0);
      @(negedge clk);
    end
    check("rstwr_ram0", {24'd0, ram_rd(32'h0000_4000)}, 32'h0000_0044);
    check("rstwr_ram2", {24'd0, ram_rd(32'h0000_4002)}, 32'h0000_0022);
    check("rstwr_ram3", {24'd0, ram_rd(32'h0000_4003)}, 32'h0000_0000);

    // ---------------- fresh IF read after reset ----------------
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_1000;
    sb_q.push_back('{1'b0, 32'h4433_2211});
    wait_done("postrst_if", 6);
    if_req_i = 1'b0;
    idle_check("postrst_idle");

    check("sb_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one byte-wide synchronous memory port between the instruction-fetch requester (IF, read-only) and the data-memory requester (ME, read/write with byte select).
- Each 32-bit word access is serialized into 4 byte accesses, little-endian. Returned bytes are reassembled into a word.
- Emits per-requester stall requests for Ctrl. It sits between the cpu core and the external RAM.

Parameters:
- ADDR_W, 32, width of byte addresses on all ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req_i  in  1  IF read request; held until if_done_o
- if_addr_i  in  ADDR_W  IF word base address
- if_data_o  out  32  fetched instruction
- if_done_o  out  1  one-cycle completion pulse for IF
- if_stall_req_o  out  1  if_req_i & ~if_done_o (combinational)
- me_req_i  in  1  ME request; held until me_done_o
- me_we_i  in  1  1 = write, 0 = read
- me_addr_i  in  ADDR_W  ME base address
- me_sel_i  in  4  byte enables for writes; bit k covers byte k
- me_w_data_i  in  32  write data
- me_r_data_o  out  32  read data
- me_done_o  out  1  one-cycle completion pulse for ME
- me_stall_req_o  out  1  me_req_i & ~me_done_o (combinational)
- mem_addr_o  out  ADDR_W  byte address to RAM (registered)
- mem_w_data_o  out  8  write byte (registered)
- mem_we_o  out  1  byte write enable (registered)
- mem_r_data_i  in  8  read byte; valid one cycle after its address is presented

Behaviour:
- Reset: synchronous, active-high.
  - State forced to IDLE; cnt = 0.
  - mem_addr_o, mem_w_data_o, mem_we_o, if_data_o, me_r_data_o, if_done_o and me_done_o all go to 0.
  - Reset takes effect at the same edge even mid-transaction. mem_we_o is low in the following cycle and no done pulse is issued.
- State machine: IDLE, RD, WR, DONE. A 3-bit cnt and a grant register (IF/ME) are held alongside it.
- IDLE, cycle T:
  - If a request is pending and arbitration grants it, latch addr, we, sel and w_data at the end of T.
  - Go to RD (ME read or IF) or WR (ME write). cnt = 0.
  - No pending request: stay in IDLE.
- Arbitration: ME has fixed priority over IF. On a simultaneous request, ME is served first and IF waits in IDLE.
- RD, cycles T+1 to T+5:
  - For cnt 0..3, mem_addr_o = base + cnt. Address arithmetic is modulo 2^ADDR_W (0xFFFFFFFF + 1 = 0x00000000).
  - For cnt 1..4, mem_r_data_i is captured into byte (cnt-1) of the granted requester's data output.
  - After cnt = 4, go to DONE.
- WR, cycles T+1 to T+4:
  - mem_addr_o = base + cnt, mem_w_data_o = w_data[8*cnt+7 : 8*cnt], mem_we_o = sel[cnt].
  - After cnt = 3, go to DONE. mem_we_o is 0 in DONE.
  - sel = 4'b0000 still runs 4 cycles with no writes.
- DONE (read T+6, write T+5):
  - The granted requester's done output is 1 for exactly one cycle; its data output is valid.
  - The next state is IDLE. A new request is therefore accepted no earlier than the following cycle.
- Data outputs hold their last value until overwritten by the next read for that requester.
- Request inputs changing after acceptance are ignored; the latched copies are used.
- A request dropped mid-transaction still completes, and its done pulse is still issued.
- Outside WR, mem_we_o = 0.
- Only one transaction is ever in flight. if_done_o and me_done_o are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - When both requests are pending in IDLE, grant the requester not granted in the previous transaction.
  - The last-grant register resets to IF, so ME wins the first tie.
  - A single pending request is always granted.
- Undefined: fixed ME-over-IF priority as above.

Test Plan:
- IF read at 0x1000, RAM bytes 11,22,33,44 -> mem_addr_o = 0x1000..0x1003 over T+1..T+4; if_data_o = 0x44332211 with if_done_o = 1 in T+6 only; if_stall_req_o = 1 in T..T+5.
- ME write at 0x2000, data 0xAABBCCDD, sel = 4'b0101 -> mem_we_o = 1 only at 0x2000 (data DD) and 0x2002 (data BB); me_done_o in T+5; RAM bytes 1 and 3 unchanged.
- IF and ME read requests both rise in the same cycle -> ME completes first (me_done_o at T+6), then IF is accepted at T+7 and if_done_o arrives at T+13. With MEM_ARB_RR_EN, a second tie is granted to IF.
- ME read at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001; the word is assembled in that byte order.
- rst asserted during the cycle with cnt = 2 of a WR -> the next cycle has mem_we_o = 0 and state IDLE, and no done pulse is issued; a fresh IF request then completes normally.
- me_addr_i changed mid-read -> the transaction still uses the latched address and the returned data matches the original address.
